// File: rtl/boa_reset_ctrl_pkg.sv
// Shared types and constants for the reset/power controller.
package boa_reset_ctrl_pkg;

  // Number of flops in each input synchroniser chain.
  localparam int unsigned SYNC_STAGES = 2;

  // Controller state; the encoding is visible on the state output.
  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_SHDN  = 2'd2
  } state_t;

endpackage

// File: rtl/boa_debounce.sv
// One button channel: two-flop synchroniser followed by a stability counter.
// The output follows the synchronised level only after it has differed for
// debounce_cycles consecutive cycles; any cycle of agreement restarts the count.
module boa_debounce
  import boa_reset_ctrl_pkg::*;
#(
  parameter int unsigned debounce_cycles = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_btn
);

  localparam int unsigned CW = $clog2(debounce_cycles) + 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_btn;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign o_btn  = r_btn;

  // Bring the raw asynchronous level into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
    end
  end

  // Accept the new level on the debounce_cycles-th consecutive differing cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_btn <= 1'b0;
    end else if (w_sync != r_btn) begin
      if (r_cnt == CW'(debounce_cycles - 1)) begin
        r_btn <= w_sync;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

endmodule

// File: rtl/boa_reset_ctrl.sv
// Reset / shutdown controller: debounces buttons, merges reset sources,
// stretches the core reset and handles shutdown with edge-triggered wake.
module boa_reset_ctrl
  import boa_reset_ctrl_pkg::*;
#(
  parameter int unsigned          num_btn         = 5,
  parameter logic [num_btn-1:0]   rst_btn_mask    = 5'b00001,
  parameter int unsigned          num_wake        = 1,
  parameter int unsigned          debounce_cycles = 100000,
  parameter int unsigned          rst_hold_cycles = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [num_btn-1:0]  btn_in,
  input  logic [num_wake-1:0] wake_in,
  input  logic                pmu_rst_req,
  input  logic                pmu_shdn_req,
  output logic [num_btn-1:0]  btn_out,
  output logic                sys_rst,
  output logic                shdn,
  output logic [1:0]          state
);

  localparam int unsigned HW = $clog2(rst_hold_cycles) + 1;
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(rst_hold_cycles - 1);

  logic [num_btn-1:0]  w_btn;
  logic [num_wake-1:0] r_wake_s1;
  logic [num_wake-1:0] r_wake_s2;
  logic [num_wake-1:0] r_wake_prev;
  logic                w_rst_src;
  logic                w_wake_evt;
  state_t              r_state;
  logic [HW-1:0]       r_hold;
  logic                r_sys_rst;
  logic                r_shdn;

  for (genvar g = 0; g < num_btn; g++) begin : g_btn
    boa_debounce #(
      .debounce_cycles(debounce_cycles)
    ) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .i_btn (btn_in[g]),
      .o_btn (w_btn[g])
    );
  end

  assign btn_out    = w_btn;
  assign w_rst_src  = pmu_rst_req | (|(w_btn & rst_btn_mask));
  assign w_wake_evt = |(r_wake_s2 & ~r_wake_prev);
  assign state      = r_state;
  assign sys_rst    = r_sys_rst;
  assign shdn       = r_shdn;

  // Synchronise wake levels and keep one cycle of history for edge detection.
  // History runs in every state, so a level already high on entering
  // shutdown never looks like a new edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wake_s1   <= '0;
      r_wake_s2   <= '0;
      r_wake_prev <= '0;
    end else begin
      r_wake_s1   <= wake_in;
      r_wake_s2   <= r_wake_s1;
      r_wake_prev <= r_wake_s2;
    end
  end

  // State machine; sys_rst/shdn are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RESET;
      r_hold    <= HOLD_RELOAD;
      r_sys_rst <= 1'b1;
      r_shdn    <= 1'b0;
    end else begin
      case (r_state)
        ST_RESET: begin
          if (w_rst_src) begin
            r_hold <= HOLD_RELOAD;
          end else if (r_hold == '0) begin
            r_state   <= ST_RUN;
            r_sys_rst <= 1'b0;
            r_shdn    <= 1'b0;
          end else begin
            r_hold <= r_hold - 1'b1;
          end
        end
        ST_RUN: begin
          if (w_rst_src) begin
            r_state   <= ST_RESET;
            r_hold    <= HOLD_RELOAD;
            r_sys_rst <= 1'b1;
            r_shdn    <= 1'b0;
          end else if (pmu_shdn_req) begin
            r_state   <= ST_SHDN;
            r_sys_rst <= 1'b0;
            r_shdn    <= 1'b1;
          end
        end
        ST_SHDN: begin
          if (w_rst_src || w_wake_evt) begin
            r_state   <= ST_RESET;
            r_hold    <= HOLD_RELOAD;
            r_sys_rst <= 1'b1;
            r_shdn    <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_RESET;
          r_hold    <= HOLD_RELOAD;
          r_sys_rst <= 1'b1;
          r_shdn    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boa_reset_ctrl.sv
// Directed bench for boa_reset_ctrl with debounce_cycles=4, rst_hold_cycles=8.
module tb_boa_reset_ctrl;

  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_SHDN  = 2'd2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] btn_in;
  logic [0:0] wake_in;
  logic       pmu_rst_req;
  logic       pmu_shdn_req;
  logic [4:0] btn_out;
  logic       sys_rst;
  logic       shdn;
  logic [1:0] state;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    logic [4:0]  btn;
    logic        wake;
    logic        rq;
    logic        sq;
    int unsigned n;
    logic [1:0]  st;
    logic        srst;
    logic        sd;
    logic [4:0]  bo;
    string       name;
  } vec_t;

  vec_t vecs[$];

  boa_reset_ctrl #(
    .num_btn        (5),
    .rst_btn_mask   (5'b00001),
    .num_wake       (1),
    .debounce_cycles(4),
    .rst_hold_cycles(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_in      (btn_in),
    .wake_in     (wake_in),
    .pmu_rst_req (pmu_rst_req),
    .pmu_shdn_req(pmu_shdn_req),
    .btn_out     (btn_out),
    .sys_rst     (sys_rst),
    .shdn        (shdn),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [1:0] st, input logic srst,
                         input logic sd, input logic [4:0] bo);
    chk({nm, ".state"},   32'(state),   32'(st));
    chk({nm, ".sys_rst"}, 32'(sys_rst), 32'(srst));
    chk({nm, ".shdn"},    32'(shdn),    32'(sd));
    chk({nm, ".btn_out"}, 32'(btn_out), 32'(bo));
  endtask

  task automatic add(input logic [4:0] btn, input logic wake, input logic rq, input logic sq,
                     input int unsigned n, input logic [1:0] st, input logic srst,
                     input logic sd, input logic [4:0] bo, input string name);
    vec_t v;
    v.btn = btn; v.wake = wake; v.rq = rq; v.sq = sq; v.n = n;
    v.st = st; v.srst = srst; v.sd = sd; v.bo = bo; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    // Each row: drive inputs, advance n cycles, compare all outputs.
    //   btn    wk rq sq  n   state    srst shdn btn_out
    add(5'h00, 0, 0, 0,  7, S_RESET, 1, 0, 5'h00, "hold7");
    add(5'h00, 0, 0, 0,  1, S_RUN,   0, 0, 5'h00, "run_after_hold");
    add(5'h04, 0, 0, 0,  5, S_RUN,   0, 0, 5'h00, "btn2_before");
    add(5'h04, 0, 0, 0,  1, S_RUN,   0, 0, 5'h04, "btn2_at6");
    add(5'h00, 0, 0, 0,  6, S_RUN,   0, 0, 5'h00, "btn2_fall");
    add(5'h04, 0, 0, 0,  3, S_RUN,   0, 0, 5'h00, "glitch_high");
    add(5'h00, 0, 0, 0,  6, S_RUN,   0, 0, 5'h00, "glitch_reject");
    add(5'h01, 0, 0, 0,  5, S_RUN,   0, 0, 5'h00, "btn0_before");
    add(5'h01, 0, 0, 0,  1, S_RUN,   0, 0, 5'h01, "btn0_at6");
    add(5'h01, 0, 0, 0,  1, S_RESET, 1, 0, 5'h01, "btn0_reset");
    add(5'h01, 0, 0, 0, 13, S_RESET, 1, 0, 5'h01, "btn0_held");
    add(5'h00, 0, 0, 0,  6, S_RESET, 1, 0, 5'h00, "btn0_fall");
    add(5'h00, 0, 0, 0,  7, S_RESET, 1, 0, 5'h00, "btn0_hold7");
    add(5'h00, 0, 0, 0,  1, S_RUN,   0, 0, 5'h00, "btn0_run");
    add(5'h00, 0, 1, 1,  1, S_RESET, 1, 0, 5'h00, "rst_beats_shdn");
    add(5'h00, 0, 0, 0,  7, S_RESET, 1, 0, 5'h00, "req_hold7");
    add(5'h00, 0, 0, 0,  1, S_RUN,   0, 0, 5'h00, "req_run");
    add(5'h00, 1, 0, 0,  3, S_RUN,   0, 0, 5'h00, "wake_pre_high");
    add(5'h00, 1, 0, 1,  1, S_SHDN,  0, 1, 5'h00, "shdn_enter");
    add(5'h00, 1, 0, 1,  5, S_SHDN,  0, 1, 5'h00, "shdn_level_ignored");
    add(5'h00, 0, 0, 0,  4, S_SHDN,  0, 1, 5'h00, "wake_low");
    add(5'h00, 1, 0, 0,  2, S_SHDN,  0, 1, 5'h00, "wake_rise_sync");
    add(5'h00, 1, 0, 0,  1, S_RESET, 1, 0, 5'h00, "wake_reset_at3");
    add(5'h00, 1, 0, 0,  7, S_RESET, 1, 0, 5'h00, "wake_hold7");
    add(5'h00, 1, 0, 0,  1, S_RUN,   0, 0, 5'h00, "wake_run");
    add(5'h00, 1, 0, 1,  1, S_SHDN,  0, 1, 5'h00, "shdn2_enter");
    add(5'h00, 1, 1, 0,  1, S_RESET, 1, 0, 5'h00, "shdn2_rst_req");
    add(5'h00, 1, 0, 0,  7, S_RESET, 1, 0, 5'h00, "shdn2_hold7");
    add(5'h00, 1, 0, 0,  1, S_RUN,   0, 0, 5'h00, "shdn2_run");
    add(5'h08, 1, 0, 0,  6, S_RUN,   0, 0, 5'h08, "btn3_nonreset");
    add(5'h08, 1, 0, 1,  1, S_SHDN,  0, 1, 5'h08, "shdn3_enter");

    rst_n        = 1'b0;
    btn_in       = '0;
    wake_in      = '0;
    pmu_rst_req  = 1'b0;
    pmu_shdn_req = 1'b0;
    tick(3);
    chk_all("por", S_RESET, 1'b1, 1'b0, 5'h00);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      btn_in       = vecs[i].btn;
      wake_in      = vecs[i].wake;
      pmu_rst_req  = vecs[i].rq;
      pmu_shdn_req = vecs[i].sq;
      tick(vecs[i].n);
      chk_all(vecs[i].name, vecs[i].st, vecs[i].srst, vecs[i].sd, vecs[i].bo);
    end

    // Asynchronous reset in the middle of a cycle while in shutdown.
    pmu_shdn_req = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", S_RESET, 1'b1, 1'b0, 5'h00);
    tick(2);
    chk_all("async_rst_held", S_RESET, 1'b1, 1'b0, 5'h00);
    rst_n = 1'b1;

    // btn_in[3] has stayed high throughout: nothing of the old debounce may
    // survive, so it needs the full 2 + 4 cycles again.
    tick(5);
    chk_all("redebounce_before", S_RESET, 1'b1, 1'b0, 5'h00);
    tick(1);
    chk_all("redebounce_at6", S_RESET, 1'b1, 1'b0, 5'h08);
    tick(1);
    chk_all("rel_hold7", S_RESET, 1'b1, 1'b0, 5'h08);
    tick(1);
    chk_all("rel_run", S_RUN, 1'b0, 1'b0, 5'h08);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
